// File: rtl/tug_match_ctrl.sv
// Tug-of-war match controller: sequences countdown, play, round hold and match end,
// gates player presses into the light chain and keeps the score.
module tug_match_ctrl #(
   parameter int unsigned SCORE_W       = 3,
   parameter int unsigned WIN_SCORE     = 7,
   parameter int unsigned CNT_W         = 4,
   parameter int unsigned COUNTDOWN_CYC = 4,
   parameter int unsigned HOLD_CYC      = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               L_in,
   input  logic               R_in,
   input  logic               left_win,
   input  logic               right_win,
   output logic               L_out,
   output logic               R_out,
   output logic               field_reset,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic               match_over,
   output logic               winner
);

   typedef enum logic [2:0] {
      IDLE,
      COUNTDOWN,
      PLAY,
      ROUND_END,
      MATCH_OVER
   } state_t;

   localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   CD_LOAD   = CNT_W'(COUNTDOWN_CYC - 1);
   localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   timer, timer_nx;
   logic [SCORE_W-1:0] score_l_nx, score_r_nx;
   logic               winner_nx;
   logic [SCORE_W-1:0] inc_l, inc_r;

   assign inc_l = score_l + SCORE_W'(1);
   assign inc_r = score_r + SCORE_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         timer   <= '0;
         score_l <= '0;
         score_r <= '0;
         winner  <= 1'b0;
      end else begin
         state   <= state_nx;
         timer   <= timer_nx;
         score_l <= score_l_nx;
         score_r <= score_r_nx;
         winner  <= winner_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      timer_nx   = timer;
      score_l_nx = score_l;
      score_r_nx = score_r;
      winner_nx  = winner;
      case (state)
         IDLE, MATCH_OVER: begin
            if (start) begin
               state_nx   = COUNTDOWN;
               timer_nx   = CD_LOAD;
               score_l_nx = '0;
               score_r_nx = '0;
            end
         end
         COUNTDOWN: begin
            if (timer == '0) state_nx = PLAY;
            else             timer_nx = timer - CNT_W'(1);
         end
         PLAY: begin
            // Simultaneous edge hits are a tie: replay the round without scoring.
            if (left_win && right_win) begin
               state_nx = ROUND_END;
               timer_nx = HOLD_LOAD;
            end else if (left_win) begin
               score_l_nx = inc_l;
               if (inc_l == WIN_S) begin
                  state_nx  = MATCH_OVER;
                  winner_nx = 1'b0;
               end else begin
                  state_nx = ROUND_END;
                  timer_nx = HOLD_LOAD;
               end
            end else if (right_win) begin
               score_r_nx = inc_r;
               if (inc_r == WIN_S) begin
                  state_nx  = MATCH_OVER;
                  winner_nx = 1'b1;
               end else begin
                  state_nx = ROUND_END;
                  timer_nx = HOLD_LOAD;
               end
            end
         end
         ROUND_END: begin
            if (timer == '0) begin
               state_nx = COUNTDOWN;
               timer_nx = CD_LOAD;
            end else begin
               timer_nx = timer - CNT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign field_reset = (state != PLAY);
   assign match_over  = (state == MATCH_OVER);
   assign L_out       = (state == PLAY) && L_in;
   assign R_out       = (state == PLAY) && R_in;

endmodule
